// File: rtl/code_lock_ctrl.sv
// Keypad code lock: digit entry, compare against a stored code,
// timed open, reprogramming from the open state and failure lockout.
module code_lock_ctrl #(
    parameter int                    N_KEYS       = 10,
    parameter int                    N_DIGITS     = 4,
    parameter logic [N_DIGITS*4-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                    T_OPEN       = 50_000_000,
    parameter int                    T_ENTRY      = 250_000_000,
    parameter int                    T_LOCKOUT    = 500_000_000,
    parameter int                    MAX_FAIL     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_p,
    input  logic              star_p,
    input  logic              prog_p,
    output logic              open_o,
    output logic              lockout_o,
    output logic              prog_o,
    output logic [3:0]        entry_cnt_o,
    output logic [3:0]        fail_cnt_o
);

    localparam int T_MAX0 = (T_OPEN > T_ENTRY) ? T_OPEN : T_ENTRY;
    localparam int T_MAX  = (T_MAX0 > T_LOCKOUT) ? T_MAX0 : T_LOCKOUT;
    localparam int TW     = $clog2(T_MAX + 1);
    localparam int CW     = N_DIGITS * 4;

    localparam logic [TW-1:0] LD_OPEN  = TW'(T_OPEN - 1);
    localparam logic [TW-1:0] LD_ENTRY = TW'(T_ENTRY - 1);
    localparam logic [TW-1:0] LD_LOCK  = TW'(T_LOCKOUT - 1);
    localparam logic [3:0]    ND       = 4'(N_DIGITS);
    localparam logic [3:0]    ND_OVF   = 4'(N_DIGITS + 1);
    localparam logic [3:0]    MF       = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_OPEN,
        S_PROG,
        S_LOCK
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [CW-1:0] entry_buf, entry_buf_n, entry_upd;
    logic [CW-1:0] code, code_n;
    logic [3:0]    cnt, cnt_n, cnt_upd;
    logic [3:0]    fail, fail_n, fail_inc;
    logic [4:0]    ones;
    logic [3:0]    digit;
    logic          valid;
    logic [TW-1:0] timer_run;

    // A digit event needs exactly one key bit; the bit index is the digit.
    always_comb begin
        ones  = '0;
        digit = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (key_p[k]) begin
                ones  = ones + 5'd1;
                digit = 4'(k);
            end
        end
        valid = (ones == 5'd1);
    end

    // Entry as it looks once this cycle's digit is accepted, so a star
    // arriving in the same cycle judges the updated entry.
    always_comb begin
        entry_upd = entry_buf;
        cnt_upd   = cnt;
        if (valid) begin
            if (cnt < ND) begin
                for (int p = 0; p < N_DIGITS; p++) begin
                    if (cnt == 4'(p)) begin
                        entry_upd[(N_DIGITS-1-p)*4 +: 4] = digit;
                    end
                end
                cnt_upd = cnt + 4'd1;
            end else begin
                cnt_upd = ND_OVF;
            end
        end
    end

    assign fail_inc  = fail + 4'd1;
    assign timer_run = valid ? LD_ENTRY :
                       (timer != '0) ? timer - TW'(1) : timer;

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        entry_buf_n = entry_buf;
        cnt_n       = cnt;
        fail_n      = fail;
        code_n      = code;
        unique case (state)
            S_IDLE, S_ENTRY: begin
                if (state == S_ENTRY || valid) begin
                    state_n     = S_ENTRY;
                    entry_buf_n = entry_upd;
                    cnt_n       = cnt_upd;
                    timer_n     = timer_run;
                    if (star_p) begin
                        entry_buf_n = '0;
                        cnt_n       = '0;
                        if (cnt_upd == ND && entry_upd == code) begin
                            state_n = S_OPEN;
                            timer_n = LD_OPEN;
                            fail_n  = '0;
                        end else if (fail_inc == MF) begin
                            state_n = S_LOCK;
                            timer_n = LD_LOCK;
                            fail_n  = fail_inc;
                        end else begin
                            state_n = S_IDLE;
                            timer_n = '0;
                            fail_n  = fail_inc;
                        end
                    end else if (!valid && timer == '0) begin
                        state_n     = S_IDLE;
                        entry_buf_n = '0;
                        cnt_n       = '0;
                    end
                end
            end
            S_OPEN: begin
                if (prog_p) begin
                    state_n     = S_PROG;
                    timer_n     = LD_ENTRY;
                    entry_buf_n = '0;
                    cnt_n       = '0;
                end else if (timer == '0) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_PROG: begin
                entry_buf_n = entry_upd;
                cnt_n       = cnt_upd;
                timer_n     = timer_run;
                if (star_p || (!valid && timer == '0)) begin
                    if (star_p && cnt_upd == ND) begin
                        code_n = entry_upd;
                    end
                    state_n     = S_IDLE;
                    timer_n     = '0;
                    entry_buf_n = '0;
                    cnt_n       = '0;
                end
            end
            S_LOCK: begin
                if (timer == '0) begin
                    state_n = S_IDLE;
                    fail_n  = '0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                state_n     = S_IDLE;
                timer_n     = '0;
                entry_buf_n = '0;
                cnt_n       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            entry_buf <= '0;
            cnt       <= '0;
            fail      <= '0;
            code      <= DEFAULT_CODE;
            open_o    <= 1'b0;
            lockout_o <= 1'b0;
            prog_o    <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            entry_buf <= entry_buf_n;
            cnt       <= cnt_n;
            fail      <= fail_n;
            code      <= code_n;
            open_o    <= (state_n == S_OPEN);
            lockout_o <= (state_n == S_LOCK);
            prog_o    <= (state_n == S_PROG);
        end
    end

    assign entry_cnt_o = cnt;
    assign fail_cnt_o  = fail;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl; expectations are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_code_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] key_p;
    logic       star_p;
    logic       prog_p;
    logic       open_o;
    logic       lockout_o;
    logic       prog_o;
    logic [3:0] entry_cnt_o;
    logic [3:0] fail_cnt_o;

    code_lock_ctrl #(
        .N_KEYS(10),
        .N_DIGITS(4),
        .DEFAULT_CODE(16'h1234),
        .T_OPEN(10),
        .T_ENTRY(50),
        .T_LOCKOUT(20),
        .MAX_FAIL(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_p(key_p),
        .star_p(star_p),
        .prog_p(prog_p),
        .open_o(open_o),
        .lockout_o(lockout_o),
        .prog_o(prog_o),
        .entry_cnt_o(entry_cnt_o),
        .fail_cnt_o(fail_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic       open;
        logic       lock;
        logic       prog;
        logic [3:0] ec;
        logic [3:0] fc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: checked late at cycle %0d, required cycle %0d",
                         e.name, cyc, e.cyc);
            end else if ({open_o, lockout_o, prog_o, entry_cnt_o, fail_cnt_o} !==
                         {e.open, e.lock, e.prog, e.ec, e.fc}) begin
                n_fail++;
                $display("FAIL %s @%0d: got open=%b lock=%b prog=%b ec=%0d fc=%0d, want open=%b lock=%b prog=%b ec=%0d fc=%0d",
                         e.name, cyc, open_o, lockout_o, prog_o, entry_cnt_o, fail_cnt_o,
                         e.open, e.lock, e.prog, e.ec, e.fc);
            end
        end
    end

    function automatic logic [9:0] kbit(input int d);
        logic [9:0] v;
        v    = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic o, input logic l,
                       input logic p, input int ec, input int fc);
        exp_t x;
        x.cyc  = cyc;
        x.name = name;
        x.open = o;
        x.lock = l;
        x.prog = p;
        x.ec   = 4'(ec);
        x.fc   = 4'(fc);
        sb.push_back(x);
    endtask

    task automatic step(input logic [9:0] k, input logic s, input logic p);
        key_p  = k;
        star_p = s;
        prog_p = p;
        @(posedge clk);
        #1;
        key_p  = '0;
        star_p = 1'b0;
        prog_p = 1'b0;
    endtask

    task automatic key(input int d, input int ec, input int fc, input logic prg);
        step(kbit(d), 1'b0, 1'b0);
        chk("digit", 1'b0, 1'b0, prg, ec, fc);
    endtask

    task automatic code4(input int a, input int b, input int c, input int d,
                         input int fc);
        key(a, 1, fc, 1'b0);
        key(b, 2, fc, 1'b0);
        key(c, 3, fc, 1'b0);
        key(d, 4, fc, 1'b0);
    endtask

    task automatic open_run(input string name);
        for (int i = 1; i <= 9; i++) begin
            step((i == 3) ? kbit(5) : 10'd0, i == 5, 1'b0);
            chk(name, 1'b1, 1'b0, 1'b0, 0, 0);
        end
        step('0, 1'b0, 1'b0);
        chk("open_end", 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst    = 1'b1;
        key_p  = '0;
        star_p = 1'b0;
        prog_p = 1'b0;
        @(posedge clk);
        #1;
        chk("reset", 1'b0, 1'b0, 1'b0, 0, 0);
        step('0, 1'b0, 1'b0);
        rst = 1'b0;
        step('0, 1'b1, 1'b0);
        chk("idle_star", 1'b0, 1'b0, 1'b0, 0, 0);

        code4(1, 2, 3, 4, 0);
        step('0, 1'b1, 1'b0);
        chk("open", 1'b1, 1'b0, 1'b0, 0, 0);
        open_run("open_hold");

        for (int r = 1; r <= 3; r++) begin
            code4(1, 2, 3, 5, r - 1);
            step('0, 1'b1, 1'b0);
            chk("bad_code", 1'b0, r == 3, 1'b0, 0, r);
        end
        for (int i = 0; i < 19; i++) begin
            step((i < 4) ? kbit(i + 1) : 10'd0, i == 4, i == 6);
            chk("lockout", 1'b0, 1'b1, 1'b0, 0, 3);
        end
        step('0, 1'b0, 1'b0);
        chk("lockout_end", 1'b0, 1'b0, 1'b0, 0, 0);

        code4(1, 2, 3, 4, 0);
        key(4, 5, 0, 1'b0);
        step(10'b0000000110, 1'b0, 1'b0);
        chk("multi_key", 1'b0, 1'b0, 1'b0, 5, 0);
        step('0, 1'b1, 1'b0);
        chk("overflow_fail", 1'b0, 1'b0, 1'b0, 0, 1);

        code4(1, 2, 3, 4, 1);
        step('0, 1'b1, 1'b0);
        chk("open_clr_fail", 1'b1, 1'b0, 1'b0, 0, 0);
        step('0, 1'b1, 1'b1);
        chk("prog_enter", 1'b0, 1'b0, 1'b1, 0, 0);
        key(9, 1, 0, 1'b1);
        key(8, 2, 0, 1'b1);
        key(7, 3, 0, 1'b1);
        key(6, 4, 0, 1'b1);
        step('0, 1'b1, 1'b0);
        chk("prog_store", 1'b0, 1'b0, 1'b0, 0, 0);
        code4(1, 2, 3, 4, 0);
        step('0, 1'b1, 1'b0);
        chk("old_code_rejected", 1'b0, 1'b0, 1'b0, 0, 1);
        code4(9, 8, 7, 6, 1);
        step('0, 1'b1, 1'b0);
        chk("new_code_opens", 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step('0, 1'b0, 1'b0);
            chk("open_before_rst", 1'b1, 1'b0, 1'b0, 0, 0);
        end
        rst = 1'b1;
        step('0, 1'b0, 1'b0);
        chk("rst_mid_open", 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        code4(1, 2, 3, 4, 0);
        step('0, 1'b1, 1'b0);
        chk("default_restored", 1'b1, 1'b0, 1'b0, 0, 0);
        open_run("open_hold2");

        code4(1, 2, 3, 5, 0);
        step('0, 1'b1, 1'b0);
        chk("bad_code2", 1'b0, 1'b0, 1'b0, 0, 1);
        key(1, 1, 1, 1'b0);
        key(2, 2, 1, 1'b0);
        for (int i = 1; i <= 49; i++) begin
            step('0, 1'b0, 1'b0);
            if (i == 49) chk("entry_hold", 1'b0, 1'b0, 1'b0, 2, 1);
        end
        step('0, 1'b0, 1'b0);
        chk("entry_timeout", 1'b0, 1'b0, 1'b0, 0, 1);

        key(1, 1, 1, 1'b0);
        key(2, 2, 1, 1'b0);
        key(3, 3, 1, 1'b0);
        step(kbit(4), 1'b1, 1'b0);
        chk("digit_with_star", 1'b1, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_fail++;
            $display("FAIL %s: never checked, required at cycle %0d", e.name, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
